// File: rtl/nios_base_cpu_oci_dct_packer.sv
// DCT trace packer: shifts 2-bit trace codes into a 15-entry accumulator and
// hands full or flushed frames to a holding register drained by valid/ready.
module nios_base_cpu_oci_dct_packer #(
  parameter int unsigned IDLE_FLUSH = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trc_on,
  input  logic [1:0]  dct_code,
  input  logic        dct_code_valid,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_overflow,
  output logic [7:0]  drop_count
);

  localparam logic [3:0] FULL     = 4'd15;
  localparam logic [8:0] IDLE_LIM = 9'(IDLE_FLUSH);

  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fv_q, fv_d;
  logic [29:0] fdata_q, fdata_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  drops_q, drops_d;
  logic        fpend_q, fpend_d;
  logic [7:0]  idle_q, idle_d;

  logic        accept, drop, hold_free, flush_req, xfer, idle_hit;
  logic [29:0] eff_buf;
  logic [3:0]  eff_cnt;

  // "Effective" accumulator: this cycle's accepted code is packed before any
  // transfer decision, so a full frame or a coincident flush leaves same edge.
  always_comb begin
    accept    = trc_on && dct_code_valid && (cnt_q != FULL);
    drop      = trc_on && dct_code_valid && (cnt_q == FULL);
    eff_buf   = accept ? {buf_q[27:0], dct_code} : buf_q;
    eff_cnt   = cnt_q + {3'b000, accept};
    hold_free = !fv_q || frame_ready;
    flush_req = fpend_q || flush;
    xfer      = hold_free && ((eff_cnt == FULL) || (flush_req && (eff_cnt != 4'd0)));
    idle_hit  = (IDLE_FLUSH != 0) && !accept && !xfer && (cnt_q != 4'd0) &&
                (({1'b0, idle_q} + 9'd1) == IDLE_LIM);
  end

  always_comb begin
    buf_d   = eff_buf;
    cnt_d   = eff_cnt;
    fv_d    = fv_q;
    fdata_d = fdata_q;
    fcnt_d  = fcnt_q;
    ovf_d   = drop;
    drops_d = drops_q;
    fpend_d = fpend_q;
    idle_d  = idle_q;

    if (drop && (drops_q != 8'hff))
      drops_d = drops_q + 8'd1;

    if (xfer) begin
      fv_d    = 1'b1;
      fdata_d = eff_buf;
      fcnt_d  = eff_cnt;
      buf_d   = '0;
      cnt_d   = '0;
    end else if (fv_q && frame_ready) begin
      fv_d = 1'b0;
    end

    // A flush that cannot complete now (holding busy) is remembered.
    if (xfer)
      fpend_d = 1'b0;
    else if ((flush && (eff_cnt != 4'd0)) || idle_hit)
      fpend_d = 1'b1;

    // Idle timer saturates at the limit; the pending flag carries the flush.
    if (accept || xfer)
      idle_d = '0;
    else if ((IDLE_FLUSH != 0) && (cnt_q != 4'd0) && ({1'b0, idle_q} < IDLE_LIM))
      idle_d = idle_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      fdata_q <= '0;
      fcnt_q  <= '0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      fpend_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      fdata_q <= fdata_d;
      fcnt_q  <= fcnt_d;
      ovf_q   <= ovf_d;
      drops_q <= drops_d;
      fpend_q <= fpend_d;
      idle_q  <= idle_d;
    end
  end

  assign frame_valid  = fv_q;
  assign frame_data   = fdata_q;
  assign frame_count  = fcnt_q;
  assign dct_buffer   = buf_q;
  assign dct_count    = cnt_q;
  assign dct_overflow = ovf_q;
  assign drop_count   = drops_q;

endmodule
